// File: rtl/arm7tdmi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm7tdmi_pkg : shared types/constants for the exception entry sequencer     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package arm7tdmi_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } processor_mode_t;

  typedef enum logic [2:0] {
    EXC_RESET = 3'd0,
    EXC_UNDEF = 3'd1,
    EXC_SWI   = 3'd2,
    EXC_PABT  = 3'd3,
    EXC_DABT  = 3'd4,
    EXC_IRQ   = 3'd5,
    EXC_FIQ   = 3'd6
  } exc_type_t;

  localparam logic [2:0] EXC_TYPE_RESERVED = 3'd7;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_SAVE    = 3'd1,
    SEQ_LINK    = 3'd2,
    SEQ_VECTOR  = 3'd3,
    SEQ_REFILL  = 3'd4,
    SEQ_RESTORE = 3'd5
  } exc_seq_state_t;

  localparam logic [3:0] LR_REG_IDX = 4'd14;

  // Only UNDEF/SWI depend on the T bit: they link to the next instruction.
  function automatic logic [3:0] lr_offset(input exc_type_t t, input logic thumb);
    logic [3:0] off;
    off = 4'd4;
    case (t)
      EXC_UNDEF, EXC_SWI: off = thumb ? 4'd2 : 4'd4;
      EXC_DABT:           off = 4'd8;
      default:            off = 4'd4;
    endcase
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm7tdmi_exc_lr_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm7tdmi_exc_lr_calc : combinational banked-LR value for exception entry    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arm7tdmi_exc_lr_calc
  import arm7tdmi_pkg::*;
(
  input  exc_type_t   exc_type_i,
  input  logic        thumb_i,
  input  logic [31:0] exec_addr_i,
  output logic [31:0] lr_o
);

  assign lr_o = exec_addr_i + {28'd0, lr_offset(exc_type_i, thumb_i)};

endmodule
`default_nettype wire

// File: rtl/arm7tdmi_exception_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm7tdmi_exception_seq : multi-cycle exception entry / return sequencer     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arm7tdmi_exception_seq
  import arm7tdmi_pkg::*;
#(
  parameter int          PIPE_REFILL = 2,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_taken,
  input  logic [2:0]  exception_type,
  input  logic [4:0]  exception_mode,
  input  logic [31:0] exception_vector,
  input  logic [31:0] exception_cpsr,
  input  logic [31:0] exception_spsr,
  input  logic [31:0] exec_addr,
  input  logic        thumb,
  input  logic        exc_return,
  input  logic [31:0] ret_addr,
  input  logic [31:0] ret_spsr,
  output logic        exception_ack,
  output logic        busy,
  output logic        stall,
  output logic        spsr_we,
  output logic [4:0]  spsr_mode,
  output logic [31:0] spsr_wdata,
  output logic        cpsr_we,
  output logic [31:0] cpsr_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_wmode,
  output logic [3:0]  rf_windex,
  output logic [31:0] rf_wdata,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        pipe_flush
);

  localparam int CNT_W = $clog2(PIPE_REFILL + 1);

  exc_seq_state_t   state_q;
  logic [CNT_W-1:0] refill_q;
  exc_type_t        type_q;
  logic [4:0]       mode_q;
  logic [31:0]      vector_q;
  logic [31:0]      lr_q;
  logic [31:0]      lr_d;
  logic             take_d;

  arm7tdmi_exc_lr_calc u_lr_calc (
    .exc_type_i  (exc_type_t'(exception_type)),
    .thumb_i     (thumb),
    .exec_addr_i (exec_addr),
    .lr_o        (lr_d)
  );

  assign take_d = exception_taken && (exception_type != EXC_TYPE_RESERVED);
  assign busy   = (state_q != SEQ_IDLE);
  assign stall  = busy;

  // Strobes are produced on the edge that enters the state they belong to,
  // so every output is a flop and drops to zero outside its own cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      refill_q      <= '0;
      type_q        <= EXC_RESET;
      mode_q        <= '0;
      vector_q      <= '0;
      lr_q          <= '0;
      exception_ack <= 1'b0;
      spsr_we       <= 1'b0;
      spsr_mode     <= '0;
      spsr_wdata    <= '0;
      cpsr_we       <= 1'b0;
      cpsr_wdata    <= '0;
      rf_we         <= 1'b0;
      rf_wmode      <= '0;
      rf_windex     <= '0;
      rf_wdata      <= '0;
      pc_load       <= 1'b0;
      pc_target     <= '0;
      pipe_flush    <= 1'b0;
    end else begin
      exception_ack <= 1'b0;
      spsr_we       <= 1'b0;
      spsr_mode     <= '0;
      spsr_wdata    <= '0;
      cpsr_we       <= 1'b0;
      cpsr_wdata    <= '0;
      rf_we         <= 1'b0;
      rf_wmode      <= '0;
      rf_windex     <= '0;
      rf_wdata      <= '0;
      pc_load       <= 1'b0;
      pc_target     <= '0;
      pipe_flush    <= 1'b0;

      case (state_q)
        SEQ_IDLE: begin
          if (take_d) begin
            state_q       <= SEQ_SAVE;
            type_q        <= exc_type_t'(exception_type);
            mode_q        <= exception_mode;
            vector_q      <= exception_vector;
            lr_q          <= lr_d;
            exception_ack <= 1'b1;
            cpsr_we       <= 1'b1;
            cpsr_wdata    <= exception_cpsr;
            if (exception_type != EXC_RESET) begin
              spsr_we    <= 1'b1;
              spsr_mode  <= exception_mode;
              spsr_wdata <= exception_spsr;
            end
          end else if (exc_return) begin
            state_q    <= SEQ_RESTORE;
            cpsr_we    <= 1'b1;
            cpsr_wdata <= ret_spsr;
            pc_load    <= 1'b1;
            pc_target  <= ret_addr;
            pipe_flush <= 1'b1;
          end
        end

        SEQ_SAVE: begin
          if (type_q == EXC_RESET) begin
            state_q    <= SEQ_VECTOR;
            pc_load    <= 1'b1;
            pc_target  <= VECTOR_BASE + vector_q;
            pipe_flush <= 1'b1;
          end else begin
            state_q   <= SEQ_LINK;
            rf_we     <= 1'b1;
            rf_wmode  <= mode_q;
            rf_windex <= LR_REG_IDX;
            rf_wdata  <= lr_q;
          end
        end

        SEQ_LINK: begin
          state_q    <= SEQ_VECTOR;
          pc_load    <= 1'b1;
          pc_target  <= VECTOR_BASE + vector_q;
          pipe_flush <= 1'b1;
        end

        SEQ_VECTOR, SEQ_RESTORE: begin
          state_q  <= SEQ_REFILL;
          refill_q <= CNT_W'(PIPE_REFILL - 1);
        end

        SEQ_REFILL: begin
          if (refill_q == '0) begin
            state_q <= SEQ_IDLE;
          end else begin
            refill_q <= refill_q - CNT_W'(1);
          end
        end

        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm7tdmi_exception_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arm7tdmi_exception_seq : random + directed bench with cycle-level model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_arm7tdmi_exception_seq;
  import arm7tdmi_pkg::*;

  localparam int          PIPE_REFILL = 2;
  localparam logic [31:0] VECTOR_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception_taken = 1'b0;
  logic [2:0]  exception_type = '0;
  logic [4:0]  exception_mode = '0;
  logic [31:0] exception_vector = '0;
  logic [31:0] exception_cpsr = '0;
  logic [31:0] exception_spsr = '0;
  logic [31:0] exec_addr = '0;
  logic        thumb = 1'b0;
  logic        exc_return = 1'b0;
  logic [31:0] ret_addr = '0;
  logic [31:0] ret_spsr = '0;
  logic        exception_ack, busy, stall, spsr_we, cpsr_we, rf_we, pc_load, pipe_flush;
  logic [4:0]  spsr_mode, rf_wmode;
  logic [3:0]  rf_windex;
  logic [31:0] spsr_wdata, cpsr_wdata, rf_wdata, pc_target;

  arm7tdmi_exception_seq #(.PIPE_REFILL(PIPE_REFILL), .VECTOR_BASE(VECTOR_BASE)) dut (
    .clk(clk), .rst(rst),
    .exception_taken(exception_taken), .exception_type(exception_type),
    .exception_mode(exception_mode), .exception_vector(exception_vector),
    .exception_cpsr(exception_cpsr), .exception_spsr(exception_spsr),
    .exec_addr(exec_addr), .thumb(thumb),
    .exc_return(exc_return), .ret_addr(ret_addr), .ret_spsr(ret_spsr),
    .exception_ack(exception_ack), .busy(busy), .stall(stall),
    .spsr_we(spsr_we), .spsr_mode(spsr_mode), .spsr_wdata(spsr_wdata),
    .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata),
    .rf_we(rf_we), .rf_wmode(rf_wmode), .rf_windex(rf_windex), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_target(pc_target), .pipe_flush(pipe_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        spsr_we;
    logic [4:0]  spsr_mode;
    logic [31:0] spsr_wdata;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic        rf_we;
    logic [4:0]  rf_wmode;
    logic [3:0]  rf_windex;
    logic [31:0] rf_wdata;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush;
    logic        busy;
    logic        stall;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t snap();
    obs_t o;
    o.ack = exception_ack; o.spsr_we = spsr_we; o.spsr_mode = spsr_mode; o.spsr_wdata = spsr_wdata;
    o.cpsr_we = cpsr_we; o.cpsr_wdata = cpsr_wdata; o.rf_we = rf_we; o.rf_wmode = rf_wmode;
    o.rf_windex = rf_windex; o.rf_wdata = rf_wdata; o.pc_load = pc_load; o.pc_target = pc_target;
    o.flush = pipe_flush; o.busy = busy; o.stall = stall;
    return o;
  endfunction

  // Reference model: a queue of expected output cycles, one entry per busy cycle.
  int unsigned off_tab [2][7] = '{'{0, 4, 4, 4, 8, 4, 4}, '{0, 2, 2, 4, 8, 4, 4}};
  obs_t exp_q[$];
  obs_t cur_exp = '0;
  bit   cur_idle = 1'b1;

  function automatic void model_exc();
    obs_t r;
    int unsigned t = 32'(exception_type);
    logic [31:0] lr = exec_addr + off_tab[thumb][t];
    r = '0; r.busy = 1; r.stall = 1; r.ack = 1; r.cpsr_we = 1; r.cpsr_wdata = exception_cpsr;
    if (t != 0) begin r.spsr_we = 1; r.spsr_mode = exception_mode; r.spsr_wdata = exception_spsr; end
    exp_q.push_back(r);
    if (t != 0) begin
      r = '0; r.busy = 1; r.stall = 1; r.rf_we = 1; r.rf_wmode = exception_mode;
      r.rf_windex = 4'd14; r.rf_wdata = lr;
      exp_q.push_back(r);
    end
    r = '0; r.busy = 1; r.stall = 1; r.pc_load = 1; r.flush = 1;
    r.pc_target = VECTOR_BASE + exception_vector;
    exp_q.push_back(r);
    r = '0; r.busy = 1; r.stall = 1;
    repeat (PIPE_REFILL) exp_q.push_back(r);
  endfunction

  function automatic void model_ret();
    obs_t r;
    r = '0; r.busy = 1; r.stall = 1; r.cpsr_we = 1; r.cpsr_wdata = ret_spsr;
    r.pc_load = 1; r.pc_target = ret_addr; r.flush = 1;
    exp_q.push_back(r);
    r = '0; r.busy = 1; r.stall = 1;
    repeat (PIPE_REFILL) exp_q.push_back(r);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_exp  = '0;
      cur_idle = 1'b1;
    end else begin
      if (cur_idle) begin
        if (exception_taken && exception_type != 3'd7) model_exc();
        else if (exc_return) model_ret();
      end
      if (exp_q.size() > 0) begin
        cur_exp  = exp_q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur_exp  = '0;
        cur_idle = 1'b1;
      end
    end
  end

  // Monitor: per-cycle comparison plus captures for the directed checks.
  logic [31:0] last_rf = '0, last_pc = '0, last_cpsr = '0, last_spsr = '0;
  logic [4:0]  last_rf_mode = '0;
  int rf_cnt = 0, spsr_cnt = 0, busy_run = 0, last_busy = 0;

  always @(negedge clk) begin
    obs_t o;
    o = snap();
    check($sformatf("cycle@%0t", $time), 160'(o), 160'(cur_exp));
    if (o.rf_we)   begin last_rf = o.rf_wdata; last_rf_mode = o.rf_wmode; rf_cnt++; end
    if (o.pc_load) last_pc = o.pc_target;
    if (o.cpsr_we) last_cpsr = o.cpsr_wdata;
    if (o.spsr_we) begin last_spsr = o.spsr_wdata; spsr_cnt++; end
    if (o.busy) busy_run++;
    else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
  end

  logic [4:0] modes [7] = '{MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS};

  task automatic do_exc(input logic [2:0] t, input logic [4:0] m, input logic [31:0] addr,
                        input logic th, input logic [31:0] cp, input logic [31:0] sp,
                        input bit with_ret, input bit ret_noise, output int waited);
    bit got = 0;
    waited = 0;
    @(negedge clk);
    exception_type = t; exception_mode = m; exception_vector = {27'd0, t, 2'b00};
    exception_cpsr = cp; exception_spsr = sp; exec_addr = addr; thumb = th;
    exception_taken = 1'b1;
    if (with_ret) begin exc_return = 1'b1; ret_addr = $urandom; ret_spsr = $urandom; end
    if (t == 3'd7) begin
      repeat (3) @(negedge clk);
      exc_return = 1'b0;
      exception_taken = 1'b0;
      return;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      exc_return = 1'b0;
      #1;
      if (exception_ack) begin got = 1; waited = i; break; end
    end
    exception_taken = 1'b0;
    check("ack_seen", 160'(got), 160'(1));
    if (ret_noise) begin
      exc_return = 1'b1; ret_addr = $urandom; ret_spsr = $urandom;
      @(negedge clk);
      exc_return = 1'b0;
    end
  endtask

  task automatic do_ret(input logic [31:0] addr, input logic [31:0] sp);
    @(negedge clk);
    exc_return = 1'b1; ret_addr = addr; ret_spsr = sp;
    @(negedge clk);
    exc_return = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin ok = 1; break; end
    end
    check("idle_reached", 160'(ok), 160'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, rc, sc;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // DABT, ARM state
    do_exc(3'd4, MODE_ABT, 32'h1000, 1'b0, 32'h600000D7, 32'h6000001F, 0, 0, w);
    check("dabt_ack_latency", 160'(w), 160'(1));
    wait_idle();
    check("dabt_spsr", 160'(last_spsr), 160'(32'h6000001F));
    check("dabt_cpsr", 160'(last_cpsr), 160'(32'h600000D7));
    check("dabt_lr",   160'(last_rf),   160'(32'h1008));
    check("dabt_pc",   160'(last_pc),   160'(32'h10));
    check("dabt_busy", 160'(last_busy), 160'(3 + PIPE_REFILL));

    // Thumb PABT and SWI
    do_exc(3'd3, MODE_ABT, 32'h2000, 1'b1, 32'h000000D7, 32'h0000003F, 0, 0, w);
    wait_idle();
    check("pabt_lr", 160'(last_rf), 160'(32'h2004));
    check("pabt_pc", 160'(last_pc), 160'(32'h0C));
    do_exc(3'd2, MODE_SVC, 32'h3002, 1'b1, 32'h000000D3, 32'h0000003F, 0, 0, w);
    wait_idle();
    check("swi_lr",   160'(last_rf),      160'(32'h3004));
    check("swi_pc",   160'(last_pc),      160'(32'h08));
    check("swi_mode", 160'(last_rf_mode), 160'(MODE_SVC));

    // RESET: no SPSR or LR write
    rc = rf_cnt; sc = spsr_cnt;
    do_exc(3'd0, MODE_SVC, 32'h4444, 1'b0, 32'h000000D3, 32'h12345678, 0, 0, w);
    wait_idle();
    check("reset_no_rf",   160'(rf_cnt),    160'(rc));
    check("reset_no_spsr", 160'(spsr_cnt),  160'(sc));
    check("reset_pc",      160'(last_pc),   160'(32'h0));
    check("reset_busy",    160'(last_busy), 160'(2 + PIPE_REFILL));

    // IRQ raised during REFILL of a DABT
    do_exc(3'd4, MODE_ABT, 32'h5000, 1'b0, 32'h600000D7, 32'h6000001F, 0, 0, w);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (pc_load) begin seen = 1; break; end
    end
    check("dabt_vector_seen", 160'(seen), 160'(1));
    do_exc(3'd5, MODE_IRQ, 32'h7000, 1'b0, 32'h600000D2, 32'h6000001F, 0, 0, w);
    check("irq_ack_wait", 160'(w), 160'(PIPE_REFILL + 1));
    wait_idle();
    check("irq_lr", 160'(last_rf), 160'(32'h7004));

    // Exception return, then return coincident with a request
    do_ret(32'h1004, 32'h6000001F);
    wait_idle();
    check("ret_cpsr", 160'(last_cpsr), 160'(32'h6000001F));
    check("ret_pc",   160'(last_pc),   160'(32'h1004));
    check("ret_busy", 160'(last_busy), 160'(1 + PIPE_REFILL));
    sc = spsr_cnt;
    do_exc(3'd1, MODE_UND, 32'h8000, 1'b0, 32'h600000DB, 32'h60000010, 1, 0, w);
    wait_idle();
    check("coinc_spsr", 160'(spsr_cnt),  160'(sc + 1));
    check("coinc_cpsr", 160'(last_cpsr), 160'(32'h600000DB));
    check("coinc_pc",   160'(last_pc),   160'(32'h04));

    // Asynchronous reset in LINK, then LR wrap-around
    do_exc(3'd4, MODE_ABT, 32'h9000, 1'b0, 32'h600000D7, 32'h6000001F, 0, 0, w);
    @(negedge clk); #1;
    check("in_link", 160'(rf_we), 160'(1));
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 160'(snap()), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    do_exc(3'd4, MODE_ABT, 32'hFFFFFFFC, 1'b0, 32'h600000D7, 32'h6000001F, 0, 0, w);
    check("post_rst_ack_latency", 160'(w), 160'(1));
    wait_idle();
    check("lr_wrap", 160'(last_rf), 160'(32'h4));

    // Randomized traffic, including reserved type, overlap and ignored returns
    for (int n = 0; n < 80; n++) begin
      int sel = int'($urandom_range(0, 9));
      if (sel < 7) begin
        logic [2:0] t = 3'($urandom_range(0, 7));
        do_exc(t, modes[$urandom_range(0, 6)], $urandom, 1'($urandom), $urandom, $urandom,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), w);
      end else begin
        do_ret($urandom, $urandom);
      end
      if ($urandom_range(0, 9) < 7) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
